perf_counter_multi: RTL and testbench
=====================================

// Module: perf_counter_multi
// PURPOSE
//  Parametrised Avalon-MM performance counter for the SoC: NUM_SECTIONS sections, each with a
//  cycle (time) counter and a go-event counter. Software brackets code with go/stop writes.
//  Adds atomic 64-bit reads, sticky overflow flags, an optional saturate mode and an overflow IRQ.
//  Sits on the system interconnect as a control slave. Fixed 4-word stride per section.
// PARAMETERS
//  NUM_SECTIONS  4   number of sections, 1..16; AW = clog2(NUM_SECTIONS)+2
//  TIME_WIDTH    64  time counter width, 33..64
//  EVENT_WIDTH   32  event counter width, 1..32
//  SATURATE      0   0: counters wrap to 0 on overflow; 1: counters hold at all-ones
// PORTS
//  clk            in   1       single clock; all state on its rising edge
//  reset          in   1       asynchronous, active-high; clears all state
//  address        in   AW      word address; [AW-1:2] = section s, [1:0] = offset
//  begintransfer  in   1       first cycle of a transfer; qualifies read and write
//  read           in   1       read request
//  write          in   1       write request
//  writedata      in   32      write data
//  readdata       out  32      registered read data, read latency 1
//  irq            out  1       registered OR over sections of (ovf_time|ovf_event) & irq_en
// BEHAVIOUR
//  Reset: all counters, enables, shadow regs, ovf flags, irq_en, readdata, irq = 0.
//  Strobes: wr = write & begintransfer; rd = read & begintransfer.
//  Offset 0 TIME_LO: read time[31:0]; write = stop(s): enable(s) <= 0 next edge.
//    Write to section 0 offset 0 with writedata[0]=1 = global_reset.
//  Offset 1 TIME_HI: read shadow_hi(s); write = go(s): enable(s) <= 1, event(s) += 1.
//  Offset 2 EVENT: read event(s), zero-extended; writes ignored.
//  Offset 3 STATUS: read {28'b0, irq_en, ovf_event, ovf_time, enable}.
//    Write: bit1/bit2 write-1-to-clear, bit3 loads irq_en; other bits ignored.
//  global_enable = enable(0) | go(0). Time(s) increments when enable(s) & global_enable.
//    Event(s) increments on go(s) & global_enable. Section 0 gates all sections, so
//    section 0 must be started first.
//  global_reset: clears every time and event counter, enable, shadow_hi and ovf flag that edge.
//    irq_en is kept. global_reset takes priority over any increment or go in the same cycle.
//  Atomic read: rd at offset 0 loads shadow_hi(s) <= time(s)[TIME_WIDTH-1:32], zero-extended,
//    on the same edge readdata captures time[31:0]. TIME_HI returns the shadow, never the live value.
//  Overflow: an increment at all-ones sets the sticky ovf flag. Result is 0 (SATURATE=0) or
//    all-ones held (SATURATE=1). A W1C in the same cycle as a new overflow leaves the flag set.
//  readdata <= mux(address) every cycle; unused addresses return 0. irq updates one cycle after a
//    flag/irq_en change.
//  go on a running section: stays enabled and counts the event. stop on an idle section: no effect.
//  Reset asserted mid-count: immediate clear, no pending strobe survives.
// STRUCTURE
//  perf_counter_pkg: offset constants OFS_TIME_LO/OFS_TIME_HI/OFS_EVENT/OFS_STATUS,
//    STATUS bit indices, and the clog2 function.
//  Sub-module perf_counter_section (instantiated NUM_SECTIONS times by generate) holds the
//    time/event counters, enable, shadow_hi and ovf/irq_en. Top holds decode, read mux and irq.
// TESTING
//  1 go(0), idle 10 cycles, stop(0) -> TIME_LO=11, TIME_HI=0, EVENT(0)=1; counter frozen after stop.
//  2 go(2) with section 0 stopped -> time(2) stays 0, event(2)=0; with section 0 running,
//    3 gos on s2 -> EVENT(2)=3.
//  3 Preload time(1)=0x0000_0001_FFFF_FFFF (force), run 1 cycle, read LO then HI -> 0x0, 0x2.
//    Then a HI read after further counting still returns shadow 0x2.
//  4 EVENT_WIDTH=4, SATURATE=0: 16 gos -> EVENT=0, STATUS.ovf_event=1. With irq_en=1, irq=1
//    the next cycle; W1C 0x4 -> irq=0. Repeat with SATURATE=1 -> EVENT=0xF.
//  5 Write 0x1 to section 0 offset 0 while all sections run -> all counters/flags 0, irq_en kept.
//    global_reset in the same cycle as go(1) -> enable(1)=0, event(1)=0.
//  6 Assert reset mid-count with a pending go -> readdata=0, irq=0, all STATUS=0 after release.

Source files
------------

// File: rtl/perf_counter_pkg.sv
// Register map, STATUS bit positions and sizing helper shared by the
// multi-section performance counter.
package perf_counter_pkg;

  typedef enum logic [1:0] {
    OFS_TIME_LO = 2'd0,
    OFS_TIME_HI = 2'd1,
    OFS_EVENT   = 2'd2,
    OFS_STATUS  = 2'd3
  } reg_offset_e;

  localparam int STAT_ENABLE    = 0;
  localparam int STAT_OVF_TIME  = 1;
  localparam int STAT_OVF_EVENT = 2;
  localparam int STAT_IRQ_EN    = 3;

  localparam int GLOBAL_RESET_BIT = 0;

  // Smallest n with 2**n >= value; written as a bounded loop so it elaborates anywhere.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/perf_counter_section.sv
// One section of the performance counter: time and go-event counters, run enable,
// atomic-read shadow of the upper time word, sticky overflow flags and irq enable.
module perf_counter_section
  import perf_counter_pkg::*;
#(
  parameter int TIME_WIDTH  = 64,
  parameter int EVENT_WIDTH = 32,
  parameter int SATURATE    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        global_reset,
  input  logic        global_enable,
  input  logic        go,
  input  logic        stop,
  input  logic        snapshot,
  input  logic        status_we,
  input  logic        clr_ovf_time,
  input  logic        clr_ovf_event,
  input  logic        irq_en_d,
  output logic [31:0] time_lo,
  output logic [31:0] shadow_hi,
  output logic [31:0] event_rd,
  output logic [31:0] status,
  output logic        irq_req
);

  logic [TIME_WIDTH-1:0]  time_cnt;
  logic [EVENT_WIDTH-1:0] event_cnt;
  logic [TIME_WIDTH-1:0]  time_next;
  logic [EVENT_WIDTH-1:0] event_next;
  logic                   enable;
  logic                   ovf_time;
  logic                   ovf_event;
  logic                   irq_en;
  logic                   time_inc;
  logic                   event_inc;
  logic                   time_at_max;
  logic                   event_at_max;

  assign time_inc     = enable & global_enable;
  assign event_inc    = go & global_enable;
  assign time_at_max  = &time_cnt;
  assign event_at_max = &event_cnt;

  // On overflow a counter either wraps to zero or parks at all-ones.
  always_comb begin
    time_next  = time_cnt + TIME_WIDTH'(1);
    event_next = event_cnt + EVENT_WIDTH'(1);
    if (time_at_max)  time_next  = (SATURATE != 0) ? time_cnt  : '0;
    if (event_at_max) event_next = (SATURATE != 0) ? event_cnt : '0;
  end

  // Global reset outranks every increment and go in the same cycle but spares irq_en.
  // A flag raised by a fresh overflow survives a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      time_cnt  <= '0;
      event_cnt <= '0;
      enable    <= 1'b0;
      shadow_hi <= '0;
      ovf_time  <= 1'b0;
      ovf_event <= 1'b0;
      irq_en    <= 1'b0;
    end else if (global_reset) begin
      time_cnt  <= '0;
      event_cnt <= '0;
      enable    <= 1'b0;
      shadow_hi <= '0;
      ovf_time  <= 1'b0;
      ovf_event <= 1'b0;
    end else begin
      if (time_inc)  time_cnt  <= time_next;
      if (event_inc) event_cnt <= event_next;
      if (go) begin
        enable <= 1'b1;
      end else if (stop) begin
        enable <= 1'b0;
      end
      if (snapshot) shadow_hi <= 32'(time_cnt[TIME_WIDTH-1:32]);
      ovf_time  <= (ovf_time  & ~(status_we & clr_ovf_time))  | (time_inc  & time_at_max);
      ovf_event <= (ovf_event & ~(status_we & clr_ovf_event)) | (event_inc & event_at_max);
      if (status_we) irq_en <= irq_en_d;
    end
  end

  assign time_lo  = time_cnt[31:0];
  assign event_rd = 32'(event_cnt);
  assign irq_req  = (ovf_time | ovf_event) & irq_en;

  always_comb begin
    status                 = '0;
    status[STAT_ENABLE]    = enable;
    status[STAT_OVF_TIME]  = ovf_time;
    status[STAT_OVF_EVENT] = ovf_event;
    status[STAT_IRQ_EN]    = irq_en;
  end

endmodule

// File: rtl/perf_counter_multi.sv
// Avalon-MM control slave wrapping NUM_SECTIONS counter sections at a 4-word stride;
// holds the address decode, the registered read mux and the registered irq.
module perf_counter_multi
  import perf_counter_pkg::*;
#(
  parameter int NUM_SECTIONS = 4,
  parameter int TIME_WIDTH   = 64,
  parameter int EVENT_WIDTH  = 32,
  parameter int SATURATE     = 0,
  localparam int AW          = clog2(NUM_SECTIONS) + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] address,
  input  logic          begintransfer,
  input  logic          read,
  input  logic          write,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  output logic          irq
);

  localparam int SW = (NUM_SECTIONS > 1) ? clog2(NUM_SECTIONS) : 1;

  logic                    wr;
  logic                    rd;
  logic [SW-1:0]           sec_idx;
  logic                    sec_valid;
  reg_offset_e             offset;
  logic                    global_reset;
  logic                    global_enable;
  logic [NUM_SECTIONS-1:0] sel;
  logic [NUM_SECTIONS-1:0] go_vec;
  logic [NUM_SECTIONS-1:0] stop_vec;
  logic [NUM_SECTIONS-1:0] snap_vec;
  logic [NUM_SECTIONS-1:0] status_we_vec;
  logic [NUM_SECTIONS-1:0] irq_req_vec;
  logic [31:0]             time_lo_arr   [NUM_SECTIONS];
  logic [31:0]             shadow_hi_arr [NUM_SECTIONS];
  logic [31:0]             event_arr     [NUM_SECTIONS];
  logic [31:0]             status_arr    [NUM_SECTIONS];
  logic [31:0]             read_mux;
  logic                    unused_wdata;

  assign wr        = write & begintransfer;
  assign rd        = read & begintransfer;
  assign sec_idx   = SW'(address >> 2);
  assign sec_valid = int'(sec_idx) < NUM_SECTIONS;
  assign offset    = reg_offset_e'(address[1:0]);

  assign global_reset  = wr && (sec_idx == '0) && (offset == OFS_TIME_LO)
                         && writedata[GLOBAL_RESET_BIT];
  // A go to section 0 opens the gate in the same cycle it is issued.
  assign global_enable = status_arr[0][STAT_ENABLE] | go_vec[0];

  assign unused_wdata = &{1'b0, writedata[31:4]};

  for (genvar s = 0; s < NUM_SECTIONS; s++) begin : gen_sec
    assign sel[s]           = sec_valid && (int'(sec_idx) == s);
    assign go_vec[s]        = wr & sel[s] & (offset == OFS_TIME_HI);
    assign stop_vec[s]      = wr & sel[s] & (offset == OFS_TIME_LO);
    assign snap_vec[s]      = rd & sel[s] & (offset == OFS_TIME_LO);
    assign status_we_vec[s] = wr & sel[s] & (offset == OFS_STATUS);

    perf_counter_section #(
      .TIME_WIDTH (TIME_WIDTH),
      .EVENT_WIDTH(EVENT_WIDTH),
      .SATURATE   (SATURATE)
    ) u_section (
      .clk          (clk),
      .reset        (reset),
      .global_reset (global_reset),
      .global_enable(global_enable),
      .go           (go_vec[s]),
      .stop         (stop_vec[s]),
      .snapshot     (snap_vec[s]),
      .status_we    (status_we_vec[s]),
      .clr_ovf_time (writedata[STAT_OVF_TIME]),
      .clr_ovf_event(writedata[STAT_OVF_EVENT]),
      .irq_en_d     (writedata[STAT_IRQ_EN]),
      .time_lo      (time_lo_arr[s]),
      .shadow_hi    (shadow_hi_arr[s]),
      .event_rd     (event_arr[s]),
      .status       (status_arr[s]),
      .irq_req      (irq_req_vec[s])
    );
  end

  // Addresses past the last section read back as zero.
  always_comb begin
    read_mux = '0;
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      if (sel[s]) begin
        case (offset)
          OFS_TIME_LO: read_mux = time_lo_arr[s];
          OFS_TIME_HI: read_mux = shadow_hi_arr[s];
          OFS_EVENT:   read_mux = event_arr[s];
          OFS_STATUS:  read_mux = status_arr[s];
          default:     read_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= read_mux;
      irq      <= |irq_req_vec;
    end
  end

endmodule

// File: tb/tb_perf_counter_multi.sv
// Scoreboard bench: a wrapping and a saturating instance share one bus and are
// compared against a cycle-level reference model of the register map.
module tb_perf_counter_multi;
  import perf_counter_pkg::*;

  localparam int NS = 3;
  localparam int TW = 40;
  localparam int EW = 4;
  localparam int AW = clog2(NS) + 2;
  localparam longint unsigned TMAX = (64'd1 << TW) - 64'd1;
  localparam int unsigned EMAX = (32'd1 << EW) - 32'd1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] address = '0;
  logic          begintransfer = 1'b0;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata_wrap;
  logic [31:0]   readdata_sat;
  logic          irq_wrap;
  logic          irq_sat;

  perf_counter_multi #(
    .NUM_SECTIONS(NS), .TIME_WIDTH(TW), .EVENT_WIDTH(EW), .SATURATE(0)
  ) u_wrap (
    .clk(clk), .reset(reset), .address(address), .begintransfer(begintransfer),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata_wrap), .irq(irq_wrap)
  );

  perf_counter_multi #(
    .NUM_SECTIONS(NS), .TIME_WIDTH(TW), .EVENT_WIDTH(EW), .SATURATE(1)
  ) u_sat (
    .clk(clk), .reset(reset), .address(address), .begintransfer(begintransfer),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata_sat), .irq(irq_sat)
  );

  always #5 clk = ~clk;

  // Reference model state, index 0 = wrapping instance, 1 = saturating instance.
  longint unsigned m_time   [2][NS];
  int unsigned     m_event  [2][NS];
  int unsigned     m_shadow [2][NS];
  bit              m_en     [2][NS];
  bit              m_ovft   [2][NS];
  bit              m_ovfe   [2][NS];
  bit              m_irqen  [2][NS];

  typedef struct packed {
    bit          chk_rd;
    logic [31:0] rd_wrap;
    logic [31:0] rd_sat;
    logic        irq_wrap;
    logic        irq_sat;
    logic [31:0] addr;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [31:0] modelRead(input int m, input int addr);
    int sec;
    int ofs;
    logic [63:0] t;
    sec = addr >> 2;
    ofs = addr & 3;
    if (sec >= NS) return 32'd0;
    t = m_time[m][sec];
    case (ofs)
      0:       return t[31:0];
      1:       return m_shadow[m][sec];
      2:       return m_event[m][sec];
      default: return {28'd0, m_irqen[m][sec], m_ovfe[m][sec], m_ovft[m][sec], m_en[m][sec]};
    endcase
  endfunction

  function automatic logic modelIrq(input int m);
    logic any;
    any = 1'b0;
    for (int s = 0; s < NS; s++)
      if ((m_ovft[m][s] || m_ovfe[m][s]) && m_irqen[m][s]) any = 1'b1;
    return any;
  endfunction

  function automatic void modelClear(input int m, input bit keep_irqen);
    for (int s = 0; s < NS; s++) begin
      m_time[m][s]   = 0;
      m_event[m][s]  = 0;
      m_shadow[m][s] = 0;
      m_en[m][s]     = 1'b0;
      m_ovft[m][s]   = 1'b0;
      m_ovfe[m][s]   = 1'b0;
      if (!keep_irqen) m_irqen[m][s] = 1'b0;
    end
  endfunction

  // One clock edge of software-visible behaviour for instance m.
  function automatic void modelStep(input int m, input bit rd, input bit wr, input int addr,
                                    input logic [31:0] wdata);
    int sec;
    int ofs;
    bit genable;
    bit hit;
    bit new_ovft;
    bit new_ovfe;
    longint unsigned t_old;
    sec = addr >> 2;
    ofs = addr & 3;
    if (wr && addr == 0 && wdata[0]) begin
      modelClear(m, 1'b1);
      return;
    end
    genable = m_en[m][0] || (wr && addr == 1);
    for (int s = 0; s < NS; s++) begin
      hit      = (sec == s);
      new_ovft = 1'b0;
      new_ovfe = 1'b0;
      t_old    = m_time[m][s];
      if (m_en[m][s] && genable) begin
        if (t_old == TMAX) begin
          new_ovft = 1'b1;
          m_time[m][s] = (m == 1) ? TMAX : 0;
        end else begin
          m_time[m][s] = t_old + 1;
        end
      end
      if (wr && hit && ofs == 1) begin
        if (genable) begin
          if (m_event[m][s] == EMAX) begin
            new_ovfe = 1'b1;
            m_event[m][s] = (m == 1) ? EMAX : 0;
          end else begin
            m_event[m][s] = m_event[m][s] + 1;
          end
        end
        m_en[m][s] = 1'b1;
      end
      if (wr && hit && ofs == 0) m_en[m][s] = 1'b0;
      if (rd && hit && ofs == 0) m_shadow[m][s] = 32'(t_old >> 32);
      if (wr && hit && ofs == 3) begin
        if (wdata[1]) m_ovft[m][s] = 1'b0;
        if (wdata[2]) m_ovfe[m][s] = 1'b0;
        m_irqen[m][s] = wdata[3];
      end
      if (new_ovft) m_ovft[m][s] = 1'b1;
      if (new_ovfe) m_ovfe[m][s] = 1'b1;
    end
  endfunction

  // Entered at a falling edge; drives one bus cycle, queues the expected response,
  // advances the model and returns at the next falling edge. rst pulses reset mid-cycle.
  task automatic applyStimulus(input bit rd, input bit wr, input bit bt, input logic [AW-1:0] addr,
                               input logic [31:0] wdata, input bit rst);
    exp_t e;
    reset         = 1'b0;
    read          = rd;
    write         = wr;
    begintransfer = bt;
    address       = addr;
    writedata     = wdata;
    e.chk_rd   = rd & bt;
    e.addr     = 32'(addr);
    e.rd_wrap  = rst ? 32'd0 : modelRead(0, int'(addr));
    e.rd_sat   = rst ? 32'd0 : modelRead(1, int'(addr));
    e.irq_wrap = rst ? 1'b0 : modelIrq(0);
    e.irq_sat  = rst ? 1'b0 : modelIrq(1);
    expq.push_back(e);
    for (int m = 0; m < 2; m++) begin
      if (rst) modelClear(m, 1'b0);
      else     modelStep(m, rd & bt, wr & bt, int'(addr), wdata);
    end
    if (rst) begin
      #2;
      reset = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic wrReg(input int sec, input int ofs, input logic [31:0] data);
    applyStimulus(1'b0, 1'b1, 1'b1, AW'(sec * 4 + ofs), data, 1'b0);
  endtask

  task automatic rdReg(input int sec, input int ofs);
    applyStimulus(1'b1, 1'b0, 1'b1, AW'(sec * 4 + ofs), 32'd0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 32'd0, 1'b0);
  endtask

  // Preload time(1) just below a 32-bit carry, entered at a falling edge.
  task forceNearCarry();
    force u_wrap.gen_sec[1].u_section.time_cnt = 40'h01_FFFF_FFFF;
    force u_sat.gen_sec[1].u_section.time_cnt  = 40'h01_FFFF_FFFF;
    #1;
    release u_wrap.gen_sec[1].u_section.time_cnt;
    release u_sat.gen_sec[1].u_section.time_cnt;
    m_time[0][1] = 64'h01_FFFF_FFFF;
    m_time[1][1] = 64'h01_FFFF_FFFF;
  endtask

  // Preload time(2) two counts below all-ones, entered at a falling edge.
  task forceNearMax();
    force u_wrap.gen_sec[2].u_section.time_cnt = 40'hFF_FFFF_FFFD;
    force u_sat.gen_sec[2].u_section.time_cnt  = 40'hFF_FFFF_FFFD;
    #1;
    release u_wrap.gen_sec[2].u_section.time_cnt;
    release u_sat.gen_sec[2].u_section.time_cnt;
    m_time[0][2] = TMAX - 2;
    m_time[1][2] = TMAX - 2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Monitor: one queued expectation per bus cycle, checked just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        if (e.chk_rd) begin
          checkOutput($sformatf("readdata_wrap@%0d", e.addr), readdata_wrap, e.rd_wrap);
          checkOutput($sformatf("readdata_sat@%0d", e.addr), readdata_sat, e.rd_sat);
        end
        checkOutput("irq_wrap", 32'(irq_wrap), 32'(e.irq_wrap));
        checkOutput("irq_sat", 32'(irq_sat), 32'(e.irq_sat));
      end
    end
  end

  initial begin
    int          r;
    logic [AW-1:0] a;
    logic [31:0] d;
    bit          bt;
    modelClear(0, 1'b0);
    modelClear(1, 1'b0);
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    for (int s = 0; s < NS + 1; s++)
      for (int o = 0; o < 4; o++) rdReg(s, o);

    $display("[TB] go/stop on section 0");
    wrReg(0, 1, 0);
    idle(10);
    wrReg(0, 0, 0);
    rdReg(0, 0); rdReg(0, 1); rdReg(0, 2);
    idle(3);
    rdReg(0, 0);

    $display("[TB] section 0 gates the others");
    wrReg(2, 1, 0);
    idle(3);
    rdReg(2, 0); rdReg(2, 2);
    wrReg(0, 1, 0);
    repeat (3) wrReg(2, 1, 0);
    rdReg(2, 2); rdReg(2, 3);

    $display("[TB] atomic 64-bit read");
    wrReg(1, 1, 0);
    forceNearCarry();
    idle(1);
    rdReg(1, 0); rdReg(1, 1);
    idle(5);
    rdReg(1, 1);

    $display("[TB] time overflow");
    forceNearMax();
    idle(4);
    rdReg(2, 3); rdReg(2, 0);
    wrReg(2, 3, 32'h2);
    rdReg(2, 3);

    $display("[TB] event overflow and irq");
    wrReg(0, 0, 32'h1);
    wrReg(0, 1, 0);
    wrReg(1, 3, 32'h8);
    repeat (16) wrReg(1, 1, 0);
    rdReg(1, 2); rdReg(1, 3);
    idle(2);
    wrReg(1, 3, 32'hC);
    idle(2);
    rdReg(1, 3);

    $display("[TB] global reset");
    wrReg(1, 1, 0); wrReg(2, 1, 0); wrReg(2, 3, 32'h8);
    idle(5);
    wrReg(0, 0, 32'h1);
    for (int s = 0; s < NS; s++)
      for (int o = 0; o < 4; o++) rdReg(s, o);
    wrReg(0, 1, 0);
    wrReg(1, 1, 0);
    wrReg(0, 0, 32'h1);
    rdReg(1, 3); rdReg(1, 2);

    $display("[TB] async reset mid-count");
    wrReg(0, 1, 0); wrReg(1, 1, 0); wrReg(1, 3, 32'h8);
    idle(3);
    applyStimulus(1'b1, 1'b1, 1'b1, AW'(2 * 4 + 1), 32'h0, 1'b1);
    for (int s = 0; s < NS; s++) begin
      rdReg(s, 3); rdReg(s, 0); rdReg(s, 2);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 99));
      a  = AW'($urandom_range(0, 15));
      d  = $urandom;
      bt = ($urandom_range(0, 9) != 0);
      if (a == '0 && $urandom_range(0, 7) != 0) d[0] = 1'b0;
      if (r < 30)       applyStimulus(1'b1, 1'b0, bt, a, d, 1'b0);
      else if (r < 55)  applyStimulus(1'b0, 1'b1, bt, a, d, 1'b0);
      else if (r == 99) applyStimulus(1'b0, 1'b0, 1'b1, a, d, 1'b1);
      else              applyStimulus(1'b0, 1'b0, 1'b0, a, d, 1'b0);
    end

    idle(2);
    @(posedge clk);
    #2;
    vectors++;
    if (expq.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
